// File: rtl/lsb_mem_unit_pkg.sv
// Shared opcode constants, ROB tag width and FSM state encoding for the
// LSB data-memory access stage.
package lsb_mem_unit_pkg;

   localparam int ROB_W = 4;

   localparam logic [5:0] OP_LB  = 6'd11;
   localparam logic [5:0] OP_LH  = 6'd12;
   localparam logic [5:0] OP_LW  = 6'd13;
   localparam logic [5:0] OP_LBU = 6'd14;
   localparam logic [5:0] OP_LHU = 6'd15;
   localparam logic [5:0] OP_SB  = 6'd16;
   localparam logic [5:0] OP_SH  = 6'd17;
   localparam logic [5:0] OP_SW  = 6'd18;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_WRITE,
      ST_READ,
      ST_RLAST,
      ST_DONE
   } state_t;

   // Index of the last byte of the access (access size minus one).
   function automatic logic [1:0] size_m1(input logic [5:0] opcode);
      case (opcode)
         OP_LH, OP_LHU, OP_SH: size_m1 = 2'd1;
         OP_LW, OP_SW:         size_m1 = 2'd3;
         default:              size_m1 = 2'd0;
      endcase
   endfunction

   function automatic logic is_store(input logic [5:0] opcode);
      is_store = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
   endfunction

endpackage

// File: rtl/lsb_mem_ext.sv
// Load-data extension: turns the assembled little-endian bytes into the
// architectural result (sign-extend LB/LH, zero-extend LBU/LHU, LW as-is).
module lsb_mem_ext
   import lsb_mem_unit_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [31:0] data,
   output logic [31:0] result
);

   always_comb begin
      result = data;
      case (opcode)
         OP_LB:   result = {{24{data[7]}}, data[7:0]};
         OP_LBU:  result = {24'b0, data[7:0]};
         OP_LH:   result = {{16{data[15]}}, data[15:0]};
         OP_LHU:  result = {16'b0, data[15:0]};
         default: result = data;
      endcase
   end

endmodule

// File: rtl/lsb_mem_unit.sv
// Data-memory access stage behind the LSB: serialises one load/store into
// byte accesses on the 8-bit RAM port. Optional: LSB_MEM_IO_STALL_EN.
module lsb_mem_unit
   import lsb_mem_unit_pkg::*;
#(
   parameter int         ADDR_W     = 32,
   parameter logic [1:0] IO_HI_BITS = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              DC_sgn,
   input  logic [ADDR_W-1:0] DC_addr,
   input  logic [31:0]       DC_val,
   input  logic [5:0]        DC_opcode,
   input  logic [ROB_W-1:0]  DC_rob_name,
   output logic              DC_sgn_in,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full,
   output logic              CDBD_sgn,
   output logic [31:0]       CDBD_result,
   output logic [ROB_W-1:0]  CDBD_ROB_name,
   input  logic              jp_wrong
);

   state_t            state, state_next;
   logic [5:0]        op;
   logic [ROB_W-1:0]  tag;
   logic [3:0][7:0]   wdata;
   logic [3:0][7:0]   rbytes;
   logic [1:0]        k;
   logic [1:0]        last_k;
   logic              last;
   logic              accept;
   logic              io_region;
   logic              io_hold;
   logic              done_set;
   logic              cdb_set;
   logic [31:0]       ext_result;

`ifdef LSB_MEM_IO_STALL_EN
   assign io_region = (DC_addr[17:16] == IO_HI_BITS);
   assign io_hold   = io_region && is_store(DC_opcode) && io_buffer_full;
`else
   logic unused_io;
   assign io_region = 1'b0;
   assign io_hold   = 1'b0;
   assign unused_io = io_buffer_full ^ (DC_addr[17:16] == IO_HI_BITS);
`endif

   assign last = (k == last_k);
   // DC_sgn is still stale high while our done pulse is out, so never accept then.
   assign accept = (state == ST_IDLE) && DC_sgn && !DC_sgn_in && !jp_wrong && !io_hold;
   assign mem_wr = rdy && (state == ST_WRITE);

   always_comb begin
      state_next = state;
      done_set   = 1'b0;
      cdb_set    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (io_region)                state_next = ST_SETTLE;
               else if (is_store(DC_opcode)) state_next = ST_WRITE;
               else                          state_next = ST_READ;
            end
         end
         ST_SETTLE: begin
            if (is_store(op))  state_next = ST_WRITE;
            else if (jp_wrong) state_next = ST_IDLE;
            else               state_next = ST_READ;
         end
         ST_WRITE: begin
            if (last) state_next = ST_DONE;
         end
         ST_READ: begin
            if (jp_wrong)  state_next = ST_IDLE;
            else if (last) state_next = ST_RLAST;
         end
         ST_RLAST: begin
            state_next = jp_wrong ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            // Committed stores always report; a flushed load vanishes silently.
            if (is_store(op)) begin
               done_set = 1'b1;
            end else if (!jp_wrong) begin
               done_set = 1'b1;
               cdb_set  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state <= ST_IDLE;
      else if (rdy) state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         DC_sgn_in     <= 1'b0;
         CDBD_sgn      <= 1'b0;
         CDBD_result   <= '0;
         CDBD_ROB_name <= '0;
         mem_a         <= '0;
         mem_dout      <= '0;
      end else if (rdy) begin
         DC_sgn_in <= done_set;
         CDBD_sgn  <= cdb_set;
         if (cdb_set) begin
            CDBD_result   <= ext_result;
            CDBD_ROB_name <= tag;
         end
         if (accept) begin
            mem_a    <= DC_addr;
            mem_dout <= DC_val[7:0];
         end else if ((state == ST_WRITE || state == ST_READ) && !last) begin
            mem_a <= mem_a + 1'b1;
            if (state == ST_WRITE) mem_dout <= wdata[k + 2'd1];
         end
      end
   end

   // RAM data lags the address by one cycle, so each capture lands on byte k-1.
   always_ff @(posedge clk) begin
      if (rdy) begin
         if (accept) begin
            op     <= DC_opcode;
            tag    <= DC_rob_name;
            wdata  <= DC_val;
            last_k <= size_m1(DC_opcode);
            k      <= 2'd0;
         end else begin
            if ((state == ST_WRITE || state == ST_READ) && !last) k <= k + 2'd1;
            if (state == ST_READ && k != 2'd0) rbytes[k - 2'd1] <= mem_din;
            if (state == ST_RLAST)             rbytes[k] <= mem_din;
         end
      end
   end

   lsb_mem_ext u_ext (
      .opcode (op),
      .data   (rbytes),
      .result (ext_result)
   );

endmodule

// File: doc/lsb_mem_unit.md
Name: lsb_mem_unit

Overview:
- Data-memory access stage directly downstream of the load/store buffer (LSB).
- Accepts one ready load/store at a time over the DC_* handshake.
- Serialises it into byte accesses on the 8-bit RAM port and sign/zero-extends load data.
- Signals completion back to the LSB; for loads, broadcasts the result on the CDBD bus to ROB/RS/LSB.

Parameters:
ADDR_W, 32, byte address width
IO_HI_BITS, 2'b11, value of addr[17:16] that marks the memory-mapped IO region

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; low = freeze
DC_sgn  in  1  LSB request valid, held until done
DC_addr  in  ADDR_W  byte address
DC_val  in  32  store data
DC_opcode  in  6  LB/LH/LW/LBU/LHU/SB/SH/SW encodings from defines.v
DC_rob_name  in  `ROBID  ROB tag of the head LSB entry
DC_sgn_in  out  1  one-cycle done pulse to LSB
mem_din  in  8  RAM read byte, valid one cycle after address
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  1 = write, 0 = read
io_buffer_full  in  1  UART TX buffer full (used only with feature)
CDBD_sgn  out  1  load result valid
CDBD_result  out  32  extended load data
CDBD_ROB_name  out  `ROBID  tag of the load
jp_wrong  in  1  misprediction flush

Behaviour:
- Reset values: DC_sgn_in=0, CDBD_sgn=0, CDBD_result=0, CDBD_ROB_name=0, mem_wr=0, mem_a=0, mem_dout=0, state=IDLE. Reset mid-access abandons the access; no done pulse.
- rdy=0: all registers hold; mem_wr forced 0 combinationally.
- Size N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW. Byte k goes to address DC_addr+k (little-endian), 32-bit wrap. No alignment check.
- States:
  - IDLE: on DC_sgn=1 and DC_sgn_in=0, latch addr/val/opcode/tag, k=0, then go to WRITE or READ. A request is never accepted in the cycle DC_sgn_in=1, because DC_sgn is still stale high.
  - WRITE: each cycle drive mem_a=addr+k, mem_dout=val[8k+7:8k], mem_wr=1, k++. After byte N-1 go to DONE. A store of N bytes pulses done at cycle N+1 after accept.
  - READ: each cycle drive mem_a=addr+k, mem_wr=0. From the second READ cycle on, capture mem_din into byte k-1. After issuing byte N-1 go to RLAST.
  - RLAST: capture final byte, go to DONE. A load of N bytes pulses done at cycle N+2 after accept.
  - DONE: DC_sgn_in=1 for exactly one cycle. For loads, CDBD_sgn=1 in the same cycle, CDBD_result extended (LB/LH sign, LBU/LHU zero, LW as-is), CDBD_ROB_name=latched tag. Then go to IDLE.
- Outside WRITE: mem_wr=0.
- jp_wrong=1:
  - In READ/RLAST, or in DONE for a load: abort to IDLE; CDBD_sgn and DC_sgn_in stay 0 (the LSB is flushed the same cycle).
  - Stores are committed and run to completion regardless.
  - In IDLE, the same-cycle request is ignored.
- Simultaneous jp_wrong and rst: reset wins.

Optional Feature:
LSB_MEM_IO_STALL_EN
- Defined: a store with addr[17:16]==IO_HI_BITS stays in IDLE (not accepted) while io_buffer_full=1, and is accepted the first cycle it is 0. Any access in the IO region is issued with its first byte only after one extra idle cycle (bus settle).
- Undefined: io_buffer_full is ignored; IO addresses are treated like RAM.

Decomposition:
- Shared package/defines.v: opcode constants LB..SW, `ROBID/`ROBSZ widths, state encoding localparams.
- One natural sub-module: lsb_mem_ext. It is combinational and takes opcode plus the 32-bit assembled bytes to the extended result; it is reused for tests.

Test Plan:
- SW addr=0x100 val=0xAABBCCDD -> mem_wr cycles write 0xDD,0xCC,0xBB,0xAA to 0x100..0x103; DC_sgn_in at cycle 5; CDBD_sgn stays 0.
- LB addr=0x200 with RAM byte 0x80, tag 3 -> DC_sgn_in and CDBD_sgn together at cycle 3; CDBD_result=0xFFFFFF80; CDBD_ROB_name=3.
- LHU addr=0x300 with bytes 0x34,0x92 -> CDBD_result=0x00009234 at cycle 4; the same test as LH gives 0xFFFF9234.
- LW in progress, jp_wrong at cycle 2 -> no DC_sgn_in, no CDBD_sgn; IDLE next cycle; a new SB is accepted after.
- DC_sgn held high across a done pulse -> no second accept in the done cycle; rdy=0 for 3 cycles mid-SW stretches completion by exactly 3 cycles with no extra writes.
- LSB_MEM_IO_STALL_EN defined: SB to 0x30000 with io_buffer_full=1 for 4 cycles -> no mem_wr until full drops; then the write of the byte completes normally.
